uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 2, clk cycles per serial bit; legal values are 2 or greater.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port uart_rx_line, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port rx_data, output, WIDTH bits: last received byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a frame completes while rx_valid=1 and rx_ready=0.

Function
REQ-011 SHALL pass uart_rx_line through a 2-flop synchronizer, reset value 1; all logic below uses the synchronized line (rxs).
REQ-012 SHALL use the frame format: start bit 0, WIDTH data bits LSB first, one stop bit 1, each bit CLKS_PER_BIT cycles.
REQ-013 SHALL implement the states IDLE, START, DATA, STOP with a bit-timer counter and a bit index counter of $clog2(WIDTH) bits.
REQ-014 IDLE: on rxs=0, SHALL go to START and load the timer so that the sample point is CLKS_PER_BIT/2 (integer division) cycles later (mid-bit).
REQ-015 START: at the sample point, if rxs=1 (glitch), SHALL return to IDLE with no output; else SHALL go to DATA with bit index 0.
REQ-016 DATA: SHALL sample every CLKS_PER_BIT cycles after the start sample, shift the sample into bit position index, and go to STOP after bit index WIDTH-1.
REQ-017 STOP: at the sample point, if rxs=1 the frame is good; if rxs=0, SHALL pulse frame_err, discard the byte, and stay in STOP until rxs=1, then go to IDLE.
REQ-018 On a good frame, in the cycle after the stop sample, SHALL load rx_data from the shift register and set rx_valid=1, then go to IDLE.
REQ-019 After the stop sample, SHALL accept a new start bit on the very next cycle (back-to-back frames).
REQ-020 rx_valid SHALL clear on the cycle after rx_valid&rx_ready; rx_data SHALL stay stable while rx_valid=1.
REQ-021 If a good frame completes while rx_valid=1 and rx_ready=0, SHALL pulse overrun, keep the old rx_data, and drop the new byte.
REQ-022 If a good frame completes in the same cycle as rx_valid&rx_ready, SHALL load the new byte, keep rx_valid=1, and not pulse overrun.
REQ-023 The latency from the stop-bit sample to rx_valid=1 SHALL be exactly 1 cycle.

Reset
REQ-024 On rst_n=0, SHALL immediately force: state IDLE; all counters 0; synchronizer and shift register to all ones; rx_data=0; rx_valid=0; frame_err=0; overrun=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no rx_valid, frame_err or overrun; after release, the next full frame SHALL be received correctly.

Structure
REQ-026 The state encoding and frame constants (start level 0, stop level 1, idle level 1) SHALL live in shared package uart_pkg, for reuse by the UART transmitter.
REQ-027 The 2-flop synchronizer SHALL be the single sub-module, sync2; the FSM, counters and shift register stay in uart_rx.

Verification
REQ-028 WIDTH=8, CLKS_PER_BIT=2, drive frame 0xFE, rx_ready=1 -> rx_data=0xFE, one-cycle rx_valid, no frame_err.
REQ-029 Drive back-to-back frames 0xFE down to 0x01 with no idle gap, rx_ready=1 -> 254 bytes received in descending order, none missing.
REQ-030 CLKS_PER_BIT=8, pulse the line low for 2 cycles -> no rx_valid, FSM back in IDLE; a following frame 0xA5 is received correctly.
REQ-031 Drive frame 0x3C with stop bit 0 held 20 cycles, then line high -> one frame_err pulse, no rx_valid; the next frame 0x5A is received correctly.
REQ-032 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, rx_valid=1, one overrun pulse; after rx_ready=1 for one cycle, rx_valid=0.
REQ-033 Assert rst_n=0 after the 4th data bit of 0x77 -> all outputs 0 immediately; after release, frame 0x88 yields rx_data=0x88.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and serial frame
// line levels. Kept separate so the transmitter can reuse them.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchronizer bringing the asynchronous serial line into
// the clk domain. Both flops reset to the idle line level so a reset never
// looks like a start bit.
//   clk   : clock
//   rst_n : async active-low reset
//   d     : asynchronous input
//   q     : synchronized output
module sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= IDLE_LVL;
            q    <= IDLE_LVL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial receiver, start bit / WIDTH data bits LSB first / one
// stop bit, CLKS_PER_BIT clocks per bit, sampling at mid-bit.
//   clk          : clock, all state on rising edge
//   rst_n        : async active-low reset
//   uart_rx_line : serial input, idle high, asynchronous to clk
//   rx_data      : last good byte, stable while rx_valid=1
//   rx_valid     : rx_data holds an unconsumed byte
//   rx_ready     : consumer accepts rx_data
//   frame_err    : one-cycle pulse when the stop bit is sampled low
//   overrun      : one-cycle pulse when a good frame is dropped because the
//                  previous byte was still unconsumed
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uart_rx_line,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);

    // Timer counts down to 0; the sample happens in the cycle it reads 0.
    // Loading N puts the sample N+1 cycles after the load.
    localparam logic [TMR_W-1:0] HALF_LD  = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LD  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic             rxs;
    uart_state_e      state;
    logic [TMR_W-1:0] timer;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] shreg;
    // Set after a low stop sample: remain in STOP until the line returns high.
    logic             stop_err;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx_line),
        .q     (rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '1;
            stop_err  <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // Consumption clear; a frame completing this cycle overrides it.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rxs == START_LVL) begin
                        state <= START;
                        timer <= HALF_LD;
                    end
                end
                START: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (rxs != START_LVL) begin
                        state <= IDLE;           // glitch, not a real start
                    end else begin
                        state   <= DATA;
                        bit_idx <= '0;
                        timer   <= FULL_LD;
                    end
                end
                DATA: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        shreg[bit_idx] <= rxs;
                        timer          <= FULL_LD;
                        if (bit_idx == LAST_IDX)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_err) begin
                        if (rxs == STOP_LVL) begin
                            state    <= IDLE;
                            stop_err <= 1'b0;
                        end
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (rxs == STOP_LVL) begin
                        // Good frame; IDLE next cycle allows back-to-back starts.
                        state <= IDLE;
                        if (rx_valid && !rx_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        stop_err  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at CLKS_PER_BIT=2 and one at
// CLKS_PER_BIT=8, sharing clock and reset. Inputs change 1 time unit after
// the rising edge; outputs are observed on the falling edge.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line2 = 1'b1, ready2 = 1'b1;
    logic       line8 = 1'b1, ready8 = 1'b1;
    logic [7:0] data2, data8;
    logic       valid2, valid8, ferr_o2, ferr_o8, ovr_o2, ovr_o8;

    always #5 clk = ~clk;

    uart_rx #(.WIDTH(8), .CLKS_PER_BIT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .uart_rx_line(line2), .rx_data(data2),
        .rx_valid(valid2), .rx_ready(ready2), .frame_err(ferr_o2), .overrun(ovr_o2));

    uart_rx #(.WIDTH(8), .CLKS_PER_BIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .uart_rx_line(line8), .rx_data(data8),
        .rx_valid(valid8), .rx_ready(ready8), .frame_err(ferr_o8), .overrun(ovr_o8));

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int t0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation counters (only ever advanced here).
    logic [7:0] q2[$], q8[$];
    int vcyc2 = 0, vcyc8 = 0, ferr2 = 0, ferr8 = 0, ovr2 = 0, ovr8 = 0, hs_cyc2 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid2) vcyc2 <= vcyc2 + 1;
            if (valid2 && ready2) begin q2.push_back(data2); hs_cyc2 <= cyc; end
            if (ferr_o2) ferr2 <= ferr2 + 1;
            if (ovr_o2)  ovr2  <= ovr2 + 1;
            if (valid8) vcyc8 <= vcyc8 + 1;
            if (valid8 && ready8) q8.push_back(data8);
            if (ferr_o8) ferr8 <= ferr8 + 1;
            if (ovr_o8)  ovr8  <= ovr8 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic hold(input int which, input logic v, input int n);
        if (which == 2) line2 = v; else line8 = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int which, input logic [7:0] d,
                              input logic stop_v, input int stop_cyc);
        int cpb;
        cpb = (which == 2) ? 2 : 8;
        t0 = cyc;
        hold(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) hold(which, d[i], cpb);
        hold(which, stop_v, stop_cyc);
    endtask

    int b_q, b_v, b_f, b_o, nerr;

    initial begin
        // Reset state
        #2;
        chk("rst_data2",  {24'd0, data2}, 32'h0);
        chk("rst_valid2", {31'd0, valid2}, 32'h0);
        chk("rst_ferr2",  {31'd0, ferr_o2}, 32'h0);
        chk("rst_ovr8",   {31'd0, ovr_o8}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        // Single frame 0xFE, one-cycle valid, 1-cycle latency after stop sample
        b_q = q2.size(); b_v = vcyc2; b_f = ferr2;
        send_frame(2, 8'hFE, 1'b1, 2);
        hold(2, 1'b1, 8);
        chk("fe_count", q2.size() - b_q, 1);
        chk("fe_data",  {24'd0, q2[b_q]}, 32'hFE);
        chk("fe_vcyc",  vcyc2 - b_v, 1);
        chk("fe_ferr",  ferr2 - b_f, 0);
        chk("fe_lat",   hs_cyc2 - t0, 22);

        // Back-to-back 0xFE..0x01 with no idle gap
        b_q = q2.size(); b_f = ferr2; b_o = ovr2;
        for (int d = 254; d >= 1; d--) send_frame(2, 8'(d), 1'b1, 2);
        hold(2, 1'b1, 8);
        chk("b2b_count", q2.size() - b_q, 254);
        nerr = 0;
        for (int i = 0; i < 254; i++)
            if (i + b_q >= q2.size() || q2[i + b_q] !== 8'(254 - i)) nerr++;
        chk("b2b_order", nerr, 0);
        chk("b2b_ferr_ovr", (ferr2 - b_f) + (ovr2 - b_o), 0);

        // Start glitch at CLKS_PER_BIT=8
        b_v = vcyc8; b_q = q8.size();
        hold(8, 1'b0, 2);
        hold(8, 1'b1, 30);
        chk("glitch_valid", vcyc8 - b_v, 0);
        chk("glitch_idle", {30'd0, u_dut8.state}, {30'd0, IDLE});
        send_frame(8, 8'hA5, 1'b1, 8);
        hold(8, 1'b1, 12);
        chk("a5_count", q8.size() - b_q, 1);
        chk("a5_data",  {24'd0, q8[b_q]}, 32'hA5);

        // Framing error: stop bit low for 20 cycles
        b_q = q2.size(); b_f = ferr2; b_v = vcyc2;
        send_frame(2, 8'h3C, 1'b0, 20);
        hold(2, 1'b1, 6);
        chk("ferr_pulses", ferr2 - b_f, 1);
        chk("ferr_novalid", vcyc2 - b_v, 0);
        send_frame(2, 8'h5A, 1'b1, 2);
        hold(2, 1'b1, 8);
        chk("5a_count", q2.size() - b_q, 1);
        chk("5a_data",  {24'd0, q2[b_q]}, 32'h5A);

        // Overrun: consumer stalled across two frames
        ready2 = 1'b0;
        b_o = ovr2;
        send_frame(2, 8'h11, 1'b1, 2);
        send_frame(2, 8'h22, 1'b1, 2);
        hold(2, 1'b1, 6);
        chk("ovr_data",   {24'd0, data2}, 32'h11);
        chk("ovr_valid",  {31'd0, valid2}, 32'h1);
        chk("ovr_pulses", ovr2 - b_o, 1);
        ready2 = 1'b1;
        @(posedge clk); #1 ready2 = 1'b0;
        @(negedge clk);
        chk("ovr_clear", {31'd0, valid2}, 32'h0);
        @(posedge clk); #1 ready2 = 1'b1;

        // Reset mid-frame after the 4th data bit of 0x77
        b_q = q2.size(); b_f = ferr2; b_o = ovr2;
        hold(2, 1'b0, 2);
        for (int i = 0; i < 4; i++) hold(2, (8'h77 >> i) & 8'h1, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data",  {24'd0, data2}, 32'h0);
        chk("mid_rst_valid", {31'd0, valid2}, 32'h0);
        chk("mid_rst_pulse", {30'd0, ferr_o2, ovr_o2}, 32'h0);
        hold(2, 1'b1, 3);
        rst_n = 1'b1;
        hold(2, 1'b1, 4);
        send_frame(2, 8'h88, 1'b1, 2);
        hold(2, 1'b1, 8);
        chk("88_count", q2.size() - b_q, 1);
        chk("88_data",  {24'd0, q2[b_q]}, 32'h88);
        chk("88_noerr", (ferr2 - b_f) + (ovr2 - b_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
